pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Takes load-use hazards from ID/EX, branch resolution

---
 rtl/riscv_ctrl_pkg.sv | 34 +++
 rtl/hazard_perf_cnt.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the pipeline: hazard FSM states, branch kinds and the ID/EX NOP bundle.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_REDIR   = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] BR_JAL  = 2'd0;
    localparam logic [1:0] BR_JALR = 2'd1;
    localparam logic [1:0] BR_BEQ  = 2'd2;
    localparam logic [1:0] BR_BNE  = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t NOP_CTRL = '0;

    // JALR targets are never predicted, so any JALR in EX forces a redirect.
    function automatic logic is_mispredict(input logic is_branch, input logic is_jalr,
                                           input logic taken, input logic prev_taken);
        return is_branch & (is_jalr | (taken != prev_taken));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous active-high clear.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a registered PC redirect.
// Define PERF_CNT_EN to add saturating memstall/load-use/mispredict counters.
module pipeline_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int PC_W = 32
`ifdef PERF_CNT_EN
    ,parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memory_stall,
    input  logic [4:0]      Rs1_1,
    input  logic [4:0]      Rs2_1,
    input  logic            use_rs1_1,
    input  logic            use_rs2_1,
    input  logic [4:0]      Rd_2,
    input  logic            mem_read_2,
    input  logic            is_branchInst_3,
    input  logic            is_jalr_3,
    input  logic            taken_3,
    input  logic            prev_taken_3,
    input  logic [PC_W-1:0] target_3,
    output logic            stall_pc,
    output logic            stall_if_id,
    output logic            stall_id_ex,
    output logic            bubble_id_ex,
    output logic            flush_if_id,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
`ifdef PERF_CNT_EN
    ,output logic [CNT_W-1:0] cnt_memstall
    ,output logic [CNT_W-1:0] cnt_loaduse
    ,output logic [CNT_W-1:0] cnt_mispredict
`endif
);

    ctrl_state_t state, next_state;
    logic        mispredict;
    logic        load_use;
    logic        load_use_raw;

    assign load_use_raw = mem_read_2 && (Rd_2 != 5'd0) &&
                          ((use_rs1_1 && (Rd_2 == Rs1_1)) || (use_rs2_1 && (Rd_2 == Rs2_1)));

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= next_state;
    end

    // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        next_state   = ST_RUN;
        mispredict   = 1'b0;
        load_use     = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (rst) begin
            next_state = ST_RUN;
        end else if (memory_stall) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            next_state  = ST_MEMWAIT;
        end else begin
            // MEMWAIT without a stall behaves exactly like RUN; only REDIR masks EX.
            mispredict   = (state != ST_REDIR) &&
                           is_mispredict(is_branchInst_3, is_jalr_3, taken_3, prev_taken_3);
            // While a redirect is pending IF/ID is being flushed, so a load-use stall is moot.
            load_use     = (state != ST_REDIR) && !redirect_valid && !mispredict && load_use_raw;
            flush_if_id  = mispredict || redirect_valid;
            bubble_id_ex = mispredict || load_use;
            stall_pc     = load_use;
            stall_if_id  = load_use;
            next_state   = mispredict ? ST_REDIR : ST_RUN;
        end
    end

    // A redirect captured before a memory stall is held until the pipeline moves again.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (memory_stall) begin
            redirect_valid <= redirect_valid;
        end else if (mispredict) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target_3;
        end else begin
            redirect_valid <= 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_memstall (
        .clk   (clk),
        .rst   (rst),
        .inc   (memory_stall),
        .count (cnt_memstall)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_loaduse (
        .clk   (clk),
        .rst   (rst),
        .inc   (load_use),
        .count (cnt_loaduse)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mispredict (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (cnt_mispredict)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counter checks apply when PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            memory_stall;
    logic [4:0]      Rs1_1, Rs2_1, Rd_2;
    logic            use_rs1_1, use_rs2_1, mem_read_2;
    logic            is_branchInst_3, is_jalr_3, taken_3, prev_taken_3;
    logic [PC_W-1:0] target_3;
    logic            stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, redirect_valid;
    logic [PC_W-1:0] redirect_pc;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_memstall, cnt_loaduse, cnt_mispredict;
`endif

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(
        .PC_W (PC_W)
`ifdef PERF_CNT_EN
        ,.CNT_W (CNT_W)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .memory_stall    (memory_stall),
        .Rs1_1           (Rs1_1),
        .Rs2_1           (Rs2_1),
        .use_rs1_1       (use_rs1_1),
        .use_rs2_1       (use_rs2_1),
        .Rd_2            (Rd_2),
        .mem_read_2      (mem_read_2),
        .is_branchInst_3 (is_branchInst_3),
        .is_jalr_3       (is_jalr_3),
        .taken_3         (taken_3),
        .prev_taken_3    (prev_taken_3),
        .target_3        (target_3),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef PERF_CNT_EN
        ,.cnt_memstall   (cnt_memstall)
        ,.cnt_loaduse    (cnt_loaduse)
        ,.cnt_mispredict (cnt_mispredict)
`endif
    );

    always #5 clk = ~clk;

    // Output bundle order: {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, redirect_valid}
    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_LDUSE  = 6'b110100;
    localparam logic [5:0] O_MISP   = 6'b000110;
    localparam logic [5:0] O_REDIR  = 6'b000011;
    localparam logic [5:0] O_MSTALL = 6'b111000;
    localparam logic [5:0] O_MSTRV  = 6'b111001;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, redirect_valid};
    endfunction

    task automatic clear_inputs();
        memory_stall    = 1'b0;
        Rs1_1 = 5'd0; Rs2_1 = 5'd0; Rd_2 = 5'd0;
        use_rs1_1 = 1'b0; use_rs2_1 = 1'b0; mem_read_2 = 1'b0;
        is_branchInst_3 = 1'b0; is_jalr_3 = 1'b0; taken_3 = 1'b0; prev_taken_3 = 1'b0;
        target_3 = '0;
    endtask

    // Advance one cycle; inputs change at posedge+1, checks land at posedge+3.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        mem_read_2 = 1'b1; Rd_2 = rd;
        Rs1_1 = rs1; use_rs1_1 = u1;
        Rs2_1 = rs2; use_rs2_1 = u2;
    endtask

    task automatic set_branch(input logic jalr, input logic tk, input logic ptk, input logic [PC_W-1:0] tgt);
        is_branchInst_3 = 1'b1; is_jalr_3 = jalr;
        taken_3 = tk; prev_taken_3 = ptk; target_3 = tgt;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        settle();
        check("reset_outs", 64'(outs()), 64'(O_NONE));
        check("reset_pc", 64'(redirect_pc), 64'h0);
        check("reset_state", 64'(dut.state), 64'(ST_RUN));

        // Load-use on rs1: one stall cycle, then clears once the load leaves EX
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        settle(); check("lu_rs1", 64'(outs()), 64'(O_LDUSE));
        step(); clear_inputs();
        settle(); check("lu_release", 64'(outs()), 64'(O_NONE));

        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        settle(); check("lu_rd0", 64'(outs()), 64'(O_NONE));
        set_load_use(5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        settle(); check("lu_no_use", 64'(outs()), 64'(O_NONE));
        set_load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        settle(); check("lu_rs2", 64'(outs()), 64'(O_LDUSE));
        step(); clear_inputs();

        // BEQ predicted not-taken, resolved taken
        set_branch(1'b0, 1'b1, 1'b0, 32'h100);
        settle(); check("beq_detect", 64'(outs()), 64'(O_MISP));
        step(); clear_inputs();
        settle(); check("beq_redir", 64'(outs()), 64'(O_REDIR));
        check("beq_pc", 64'(redirect_pc), 64'h100);
        check("beq_state", 64'(dut.state), 64'(ST_REDIR));
        step();
        settle(); check("beq_after", 64'(outs()), 64'(O_NONE));
        check("beq_run", 64'(dut.state), 64'(ST_RUN));

        set_branch(1'b0, 1'b1, 1'b1, 32'h300);
        settle(); check("br_correct", 64'(outs()), 64'(O_NONE));

        // JALR always redirects
        set_branch(1'b1, 1'b1, 1'b1, 32'h2C);
        settle(); check("jalr_detect", 64'(outs()), 64'(O_MISP));
        step(); clear_inputs();
        settle(); check("jalr_redir", 64'(outs()), 64'(O_REDIR));
        check("jalr_pc", 64'(redirect_pc), 64'h2C);
        step();

        // Memory stall masks a simultaneous mispredict and load-use
        memory_stall = 1'b1;
        set_branch(1'b0, 1'b1, 1'b0, 32'h200);
        set_load_use(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle(); check($sformatf("ms_stall%0d", i), 64'(outs()), 64'(O_MSTALL));
            step();
        end
        check("ms_state", 64'(dut.state), 64'(ST_MEMWAIT));
        check("ms_pc_hold", 64'(redirect_pc), 64'h2C);
        memory_stall = 1'b0;
        settle(); check("ms_release", 64'(outs()), 64'(O_MISP));
        step(); clear_inputs();
        settle(); check("ms_redir", 64'(outs()), 64'(O_REDIR));
        check("ms_pc", 64'(redirect_pc), 64'h200);
        step();
        settle(); check("ms_after", 64'(outs()), 64'(O_NONE));

        // Registered redirect survives a memory stall, drops after the first free cycle
        set_branch(1'b0, 1'b0, 1'b1, 32'h440);
        step(); clear_inputs();
        memory_stall = 1'b1;
        settle(); check("rvh_stall0", 64'(outs()), 64'(O_MSTRV));
        step();
        settle(); check("rvh_stall1", 64'(outs()), 64'(O_MSTRV));
        step(); memory_stall = 1'b0;
        settle(); check("rvh_release", 64'(outs()), 64'(O_REDIR));
        check("rvh_pc", 64'(redirect_pc), 64'h440);
        step();
        settle(); check("rvh_after", 64'(outs()), 64'(O_NONE));

`ifdef PERF_CNT_EN
        check("cnt_memstall", 64'(cnt_memstall), 64'd5);
        check("cnt_loaduse", 64'(cnt_loaduse), 64'd2);
        check("cnt_mispredict", 64'(cnt_mispredict), 64'd4);
`endif

        // Reset while in REDIR discards the pending redirect
        set_branch(1'b0, 1'b1, 1'b0, 32'h880);
        step(); clear_inputs();
        check("rst_pre_state", 64'(dut.state), 64'(ST_REDIR));
        rst = 1'b1;
        step(); rst = 1'b0;
        settle(); check("rst_outs", 64'(outs()), 64'(O_NONE));
        check("rst_pc", 64'(redirect_pc), 64'h0);
        check("rst_state", 64'(dut.state), 64'(ST_RUN));
`ifdef PERF_CNT_EN
        check("rst_cnt", 64'(cnt_mispredict), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
